z80_dma_busctl: RTL and testbench
=================================

Name: z80_dma_busctl

Overview:
- Bus-master DMA controller placed beside the tv80s core.
- Requests the CPU bus via busrq_n/busak_n, performs a memory-to-memory block copy (LDIR-like) on the shared 64K memory, then returns the bus.
- Splits long transfers into bursts and releases the bus between them, so the CPU keeps making progress.
- The bench/top muxes A/data/strobes to memory from this block whenever bus_own=1.

Parameters:
- BURST_LEN, 16: maximum bytes transferred per bus ownership before yielding.
- GAP_CYCLES, 4: clocks after a yield (busak_n seen high) before busrq_n is reasserted.
- RD_WAIT, 1: extra clocks the read strobe is held; total read = RD_WAIT+1 clocks.
- WR_WAIT, 0: extra clocks the write strobe is held; total write = WR_WAIT+1 clocks.

Ports:
- clk  in  1  system clock, same clock as cpu.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- src_addr  in  16  source start address, latched on start.
- dst_addr  in  16  destination start address, latched on start.
- len  in  16  byte count, latched on start; 0 = no transfer.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle completion pulse.
- busrq_n  out  1  to cpu busrq_n.
- busak_n  in  1  from cpu busak_n.
- bus_own  out  1  high in RD/WR/NEXT; selects DMA drive onto the memory bus.
- dma_a  out  16  memory address.
- dma_do  out  8  write data.
- dma_di  in  8  read data from memory.
- dma_mreq_n, dma_rd_n, dma_wr_n  out  1 each  active-low strobes.

Behaviour:
- Reset values: busrq_n=1, busy=0, done=0, bus_own=0, dma_a=0, dma_do=0, strobes=1, state=IDLE, all counters=0. Reset during any state aborts immediately: busrq_n=1 and strobes inactive in the same cycle reset is sampled.
- States: IDLE, REQ, RD, WR, NEXT, REL, GAP, DONE.
- IDLE:
  - start with len!=0: latch src/dst/len, clear burst_cnt, go to REQ.
  - start with len==0: go to DONE; no bus request is made.
  - start while not in IDLE is ignored.
- REQ: busrq_n=0. Go to RD on the first posedge where busak_n==0. There is no timeout.
- RD:
  - dma_a=src, mreq_n=0, rd_n=0 for RD_WAIT+1 clocks.
  - dma_di is captured into the data register on the last RD clock (memory has 1-clock read latency).
  - Then go to WR.
- WR: dma_a=dst, dma_do=data, mreq_n=0, wr_n=0 for WR_WAIT+1 clocks, then go to NEXT.
- NEXT: all strobes inactive; src+=1, dst+=1, remaining-=1, burst_cnt+=1, each with 16-bit wrap (FFFF->0000).
  - remaining becomes 0: go to REL, final.
  - otherwise burst_cnt==BURST_LEN: go to REL, yield; burst_cnt cleared.
  - otherwise: go to RD.
- REL: busrq_n=1 and bus_own=0. Wait for busak_n==1.
  - Final: go to DONE.
  - Yield: go to GAP.
- GAP: count GAP_CYCLES clocks with busrq_n=1, then go to REQ.
- DONE: done=1 and busy=0 for one clock, then go to IDLE.
- Rules:
  - rd_n and wr_n are never low in the same cycle.
  - busrq_n stays low continuously from REQ through NEXT.
  - Overlapping src/dst ranges give forward-copy (LDIR) semantics.

Optional Feature:
- Macro: Z80_DMA_SEARCH_EN.
- With the macro defined, extra ports are added: cmp_mode in 1, match_val in 8, match out 1, match_addr out 16. cmp_mode and match_val are latched on start.
- When cmp_mode=1:
  - WR is skipped (RD goes straight to NEXT), giving CPIR-like search.
  - In NEXT, if data==match_val: match=1, match_addr = src before increment, go to REL final.
  - match and match_addr hold until the next accepted start, which clears match.
- Without the macro: these ports are absent and behaviour is copy-only.

Decomposition:
- Package z80_dma_pkg: state enum, DMA_ADDR_W=16, DMA_DATA_W=8.
- Sub-module z80_busreq_hs: REQ/REL/GAP handshake and gap counter. Interface: want_bus in, granted out, released out.

Test Plan:
- Basic copy: src=9825, dst=A000, len=3, mem[9825..9827]=50,E5,41, busak_n low 2 clocks after busrq_n -> mem[A000..A002]=50,E5,41; done pulses once; busrq_n=1 afterward; exactly 3 wr_n pulses.
- Zero length: len=0 -> done is high exactly 2 clocks after start; busrq_n never goes low; no strobes.
- Burst yield: len=40, BURST_LEN=16 -> 3 bus ownerships of 16,16,8 bytes; busrq_n high for at least GAP_CYCLES between them; all 40 bytes copied.
- Address wrap: src=FFFE, dst=7FFE, len=4 -> bytes read from FFFE, FFFF, 0000, 0001; written to 7FFE..8001.
- Reset mid-transfer: assert reset during WR of byte 2 -> the next clock shows busrq_n=1, strobes=1, busy=0; a following start works normally.
- Search (Z80_DMA_SEARCH_EN): src=9825, len=8, match_val=F4, data 50,E5,41,F4 -> match=1, match_addr=9828; only 4 rd_n pulses; no writes.

Source files
------------

// File: rtl/z80_dma_pkg.sv
// Shared types and widths for the z80 DMA bus controller slice.
package z80_dma_pkg;

   localparam int unsigned DMA_ADDR_W = 16;
   localparam int unsigned DMA_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RD,
      ST_WR,
      ST_NEXT,
      ST_REL,
      ST_GAP,
      ST_DONE
   } dma_state_e;

   // Live copy job: running source/destination pointers and bytes still to move.
   typedef struct packed {
      logic [DMA_ADDR_W-1:0] src;
      logic [DMA_ADDR_W-1:0] dst;
      logic [DMA_ADDR_W-1:0] rem;
   } dma_job_t;

   function automatic logic [DMA_ADDR_W-1:0] addr_inc(input logic [DMA_ADDR_W-1:0] a);
      return a + DMA_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/z80_dma_busctl_if.sv
// Shared-bus signals between the DMA master and the CPU/memory side.
interface z80_dma_busctl_if;
   import z80_dma_pkg::*;

   logic                  busrq_n;
   logic                  busak_n;
   logic                  bus_own;
   logic [DMA_ADDR_W-1:0] dma_a;
   logic [DMA_DATA_W-1:0] dma_do;
   logic [DMA_DATA_W-1:0] dma_di;
   logic                  dma_mreq_n;
   logic                  dma_rd_n;
   logic                  dma_wr_n;

   modport master (
      output busrq_n, bus_own, dma_a, dma_do, dma_mreq_n, dma_rd_n, dma_wr_n,
      input  busak_n, dma_di
   );

   modport slave (
      input  busrq_n, bus_own, dma_a, dma_do, dma_mreq_n, dma_rd_n, dma_wr_n,
      output busak_n, dma_di
   );

endinterface

// File: rtl/z80_busreq_hs.sv
// busrq_n/busak_n handshake decode plus the post-yield gap counter.
module z80_busreq_hs #(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic want_bus,
   input  logic busak_n,
   input  logic in_gap,
   output logic busrq_n,
   output logic granted,
   output logic released,
   output logic gap_done_c
);

   localparam int unsigned GAP_W    = 16;
   localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

   logic [GAP_W-1:0] gap_cnt;

   // Counts clocks spent in GAP; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         gap_cnt <= '0;
      end else if (!in_gap) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   // want_bus is a flop in the parent, so busrq_n is glitch-free.
   assign busrq_n    = ~want_bus;
   assign granted    = want_bus & ~busak_n;
   assign released   = ~want_bus & busak_n;
   assign gap_done_c = in_gap && (gap_cnt >= GAP_W'(GAP_LAST));

endmodule

// File: rtl/z80_dma_busctl.sv
// Bus-mastering LDIR-style block copy beside the tv80s core, yielding the bus between bursts.
// Define Z80_DMA_SEARCH_EN to add the CPIR-style compare/search mode.
module z80_dma_busctl
   import z80_dma_pkg::*;
#(
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned RD_WAIT    = 1,
   parameter int unsigned WR_WAIT    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DMA_ADDR_W-1:0] src_addr,
   input  logic [DMA_ADDR_W-1:0] dst_addr,
   input  logic [DMA_ADDR_W-1:0] len,
   output logic                  busy,
   output logic                  done,
`ifdef Z80_DMA_SEARCH_EN
   input  logic                  cmp_mode,
   input  logic [DMA_DATA_W-1:0] match_val,
   output logic                  match,
   output logic [DMA_ADDR_W-1:0] match_addr,
`endif
   z80_dma_busctl_if.master      bus
);

   localparam int unsigned WAIT_W = 8;

   dma_state_e            state;
   dma_job_t              job;
   logic [DMA_ADDR_W-1:0] burst_cnt;
   logic [DMA_ADDR_W-1:0] burst_nxt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [DMA_DATA_W-1:0] data;
   logic [DMA_ADDR_W-1:0] dma_a_q;
   logic                  final_q;
   logic                  want_bus;
   logic                  bus_own_q;
   logic                  mreq_n_q;
   logic                  rd_n_q;
   logic                  wr_n_q;
   logic                  busrq_n_w;
   logic                  granted;
   logic                  released;
   logic                  gap_done_c;
   logic                  in_gap_c;
   logic                  search_c;
   logic                  hit_c;
   logic                  last_c;
   logic                  burst_full_c;

`ifdef Z80_DMA_SEARCH_EN
   logic                  cmp_q;
   logic [DMA_DATA_W-1:0] mval_q;
   assign search_c = cmp_q;
   assign hit_c    = cmp_q && (data == mval_q);
`else
   assign search_c = 1'b0;
   assign hit_c    = 1'b0;
`endif

   assign in_gap_c     = (state == ST_GAP);
   assign burst_nxt    = burst_cnt + DMA_ADDR_W'(1);
   assign last_c       = (job.rem == DMA_ADDR_W'(1));
   assign burst_full_c = (burst_nxt == DMA_ADDR_W'(BURST_LEN));

   z80_busreq_hs #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_hs (
      .clk        (clk),
      .reset      (reset),
      .want_bus   (want_bus),
      .busak_n    (bus.busak_n),
      .in_gap     (in_gap_c),
      .busrq_n    (busrq_n_w),
      .granted    (granted),
      .released   (released),
      .gap_done_c (gap_done_c)
   );

   assign bus.busrq_n    = busrq_n_w;
   assign bus.bus_own    = bus_own_q;
   assign bus.dma_a      = dma_a_q;
   assign bus.dma_do     = data;
   assign bus.dma_mreq_n = mreq_n_q;
   assign bus.dma_rd_n   = rd_n_q;
   assign bus.dma_wr_n   = wr_n_q;

   // Outputs are loaded on the transition into each state so they are valid for its whole duration.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         job       <= '0;
         burst_cnt <= '0;
         wait_cnt  <= '0;
         data      <= '0;
         dma_a_q   <= '0;
         final_q   <= 1'b0;
         want_bus  <= 1'b0;
         bus_own_q <= 1'b0;
         mreq_n_q  <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef Z80_DMA_SEARCH_EN
         cmp_q      <= 1'b0;
         mval_q     <= '0;
         match      <= 1'b0;
         match_addr <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
`ifdef Z80_DMA_SEARCH_EN
                  cmp_q  <= cmp_mode;
                  mval_q <= match_val;
                  match  <= 1'b0;
`endif
                  if (len == '0) begin
                     state <= ST_DONE;
                  end else begin
                     job.src   <= src_addr;
                     job.dst   <= dst_addr;
                     job.rem   <= len;
                     burst_cnt <= '0;
                     want_bus  <= 1'b1;
                     state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (granted) begin
                  bus_own_q <= 1'b1;
                  dma_a_q   <= job.src;
                  mreq_n_q  <= 1'b0;
                  rd_n_q    <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ST_RD;
               end
            end
            ST_RD: begin
               // Memory answers one clock after the address, so sample on the last read clock.
               if (wait_cnt == WAIT_W'(RD_WAIT)) begin
                  data     <= bus.dma_di;
                  rd_n_q   <= 1'b1;
                  wait_cnt <= '0;
                  if (search_c) begin
                     mreq_n_q <= 1'b1;
                     state    <= ST_NEXT;
                  end else begin
                     dma_a_q <= job.dst;
                     wr_n_q  <= 1'b0;
                     state   <= ST_WR;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_WR: begin
               if (wait_cnt == WAIT_W'(WR_WAIT)) begin
                  mreq_n_q <= 1'b1;
                  wr_n_q   <= 1'b1;
                  state    <= ST_NEXT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_NEXT: begin
               job.src   <= addr_inc(job.src);
               job.dst   <= addr_inc(job.dst);
               job.rem   <= job.rem - DMA_ADDR_W'(1);
               burst_cnt <= burst_nxt;
`ifdef Z80_DMA_SEARCH_EN
               if (hit_c) begin
                  match      <= 1'b1;
                  match_addr <= job.src;
               end
`endif
               if (last_c || hit_c) begin
                  final_q   <= 1'b1;
                  want_bus  <= 1'b0;
                  bus_own_q <= 1'b0;
                  state     <= ST_REL;
               end else if (burst_full_c) begin
                  final_q   <= 1'b0;
                  want_bus  <= 1'b0;
                  bus_own_q <= 1'b0;
                  burst_cnt <= '0;
                  state     <= ST_REL;
               end else begin
                  dma_a_q  <= addr_inc(job.src);
                  mreq_n_q <= 1'b0;
                  rd_n_q   <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ST_RD;
               end
            end
            ST_REL: begin
               if (released) begin
                  state <= final_q ? ST_DONE : ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_done_c) begin
                  want_bus <= 1'b1;
                  state    <= ST_REQ;
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80_dma_busctl.sv
// Directed bench for z80_dma_busctl: memory + busak model, read/write/ownership scoreboards.
module tb_z80_dma_busctl;
   import z80_dma_pkg::*;

   localparam int unsigned BURST = 16;
   localparam int unsigned GAP   = 4;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] src_addr, dst_addr, len;
   logic        busy, done;
`ifdef Z80_DMA_SEARCH_EN
   logic        cmp_mode;
   logic [7:0]  match_val;
   logic        match;
   logic [15:0] match_addr;
`endif

   z80_dma_busctl_if bus();

   z80_dma_busctl #(
      .BURST_LEN (BURST),
      .GAP_CYCLES(GAP),
      .RD_WAIT   (1),
      .WR_WAIT   (0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
`ifdef Z80_DMA_SEARCH_EN
      .cmp_mode  (cmp_mode),
      .match_val (match_val),
      .match     (match),
      .match_addr(match_addr),
`endif
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int  total = 0;
   int  bad   = 0;
   wr_t exp_wr[$];
   logic [15:0] exp_rd[$];
   int  exp_own[$];

   logic [7:0] mem [65536];
   logic       rq_d1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CPU grants/releases the bus two clocks after busrq_n changes.
   always @(posedge clk) begin
      if (reset) begin
         rq_d1       <= 1'b1;
         bus.busak_n <= 1'b1;
      end else begin
         rq_d1       <= bus.busrq_n;
         bus.busak_n <= rq_d1;
      end
   end

   // Synchronous memory with one clock of read latency.
   always @(posedge clk) begin
      if (bus.dma_mreq_n == 1'b0 && bus.dma_wr_n == 1'b0) mem[bus.dma_a] = bus.dma_do;
      bus.dma_di <= mem[bus.dma_a];
   end

   int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, rq_fall = 0, own_wr = 0, hi_run = 0;
   logic p_wr = 1'b1, p_rd = 1'b1, p_rq = 1'b1, p_done = 1'b0;
   wr_t  ew;
   logic [15:0] er;
   int   eo;

   always @(negedge clk) begin
      if (bus.dma_wr_n === 1'b0 && p_wr === 1'b1) begin
         wr_cnt++;
         own_wr++;
         if (exp_wr.size() == 0) chk("wr_unexpected", 32'(bus.dma_a), 32'hFFFF_FFFF);
         else begin
            ew = exp_wr.pop_front();
            chk("wr_addr", 32'(bus.dma_a), 32'(ew.a));
            chk("wr_data", 32'(bus.dma_do), 32'(ew.d));
         end
      end
      if (bus.dma_rd_n === 1'b0 && p_rd === 1'b1) begin
         rd_cnt++;
         if (exp_rd.size() == 0) chk("rd_unexpected", 32'(bus.dma_a), 32'hFFFF_FFFF);
         else begin
            er = exp_rd.pop_front();
            chk("rd_addr", 32'(bus.dma_a), 32'(er));
         end
      end
      if (bus.dma_rd_n === 1'b0 && bus.dma_wr_n === 1'b0) chk("rd_wr_overlap", 32'(1), 32'(0));
      if (bus.bus_own === 1'b1 && bus.busrq_n !== 1'b0) chk("busrq_while_own", 32'(bus.busrq_n), 32'(0));
      if (busy !== 1'b1) hi_run = 0;
      else if (bus.busrq_n === 1'b1) hi_run++;
      if (bus.busrq_n === 1'b0 && p_rq === 1'b1) begin
         rq_fall++;
         if (hi_run > 0) chk("gap_len_ok", 32'(hi_run >= int'(GAP)), 32'(1));
         hi_run = 0;
      end
      if (bus.busrq_n === 1'b1 && p_rq === 1'b0) begin
         if (exp_own.size() == 0) chk("own_unexpected", 32'(own_wr), 32'hFFFF_FFFF);
         else begin
            eo = exp_own.pop_front();
            chk("own_bytes", 32'(own_wr), 32'(eo));
         end
         own_wr = 0;
      end
      if (done === 1'b1 && p_done !== 1'b1) done_cnt++;
      p_wr   = bus.dma_wr_n;
      p_rd   = bus.dma_rd_n;
      p_rq   = bus.busrq_n;
      p_done = done;
   end

   task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
      wr_t w;
      int  rem = n;
      int  c;
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(s + 16'(i));
         w.a = d + 16'(i);
         w.d = mem[s + 16'(i)];
         exp_wr.push_back(w);
      end
      while (rem > 0) begin
         c = (rem > int'(BURST)) ? int'(BURST) : rem;
         exp_own.push_back(c);
         rem -= c;
      end
   endtask

   task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      src_addr = s;
      dst_addr = d;
      len      = n;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base, input int budget);
      int n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_cnt != base), 32'(1));
   endtask

   initial begin
      int          d0, w0, r0, q0, k;
      logic        pw;
      logic [7:0]  saved [40];

      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef Z80_DMA_SEARCH_EN
      cmp_mode = 1'b0; match_val = '0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busrq_n", 32'(bus.busrq_n), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_bus_own", 32'(bus.bus_own), 32'(0));
      chk("rst_dma_a", 32'(bus.dma_a), 32'(0));
      chk("rst_dma_do", 32'(bus.dma_do), 32'(0));
      chk("rst_strobes", 32'({bus.dma_mreq_n, bus.dma_rd_n, bus.dma_wr_n}), 32'(3'b111));
      reset = 1'b0;
      @(negedge clk);

      // Basic copy
      mem[16'h9825] = 8'h50; mem[16'h9826] = 8'hE5; mem[16'h9827] = 8'h41;
      d0 = done_cnt; w0 = wr_cnt;
      push_copy(16'h9825, 16'hA000, 3);
      pulse_start(16'h9825, 16'hA000, 16'd3);
      chk("copy_busy", 32'(busy), 32'(1));
      wait_done("copy_done_seen", d0, 400);
      repeat (4) @(negedge clk);
      chk("copy_mem0", 32'(mem[16'hA000]), 32'h50);
      chk("copy_mem1", 32'(mem[16'hA001]), 32'hE5);
      chk("copy_mem2", 32'(mem[16'hA002]), 32'h41);
      chk("copy_done_once", 32'(done_cnt - d0), 32'(1));
      chk("copy_wr_pulses", 32'(wr_cnt - w0), 32'(3));
      chk("copy_busrq_idle", 32'(bus.busrq_n), 32'(1));
      chk("copy_busy_end", 32'(busy), 32'(0));

      // Zero length
      q0 = rq_fall; r0 = rd_cnt; w0 = wr_cnt;
      pulse_start(16'h1234, 16'h5678, 16'd0);
      chk("zero_busy", 32'(busy), 32'(1));
      chk("zero_done_early", 32'(done), 32'(0));
      @(negedge clk);
      chk("zero_done", 32'(done), 32'(1));
      chk("zero_busy_done", 32'(busy), 32'(0));
      @(negedge clk);
      chk("zero_done_pulse", 32'(done), 32'(0));
      repeat (3) @(negedge clk);
      chk("zero_no_busrq", 32'(rq_fall - q0), 32'(0));
      chk("zero_no_rd", 32'(rd_cnt - r0), 32'(0));
      chk("zero_no_wr", 32'(wr_cnt - w0), 32'(0));

      // Burst yield: 40 bytes -> 16,16,8
      for (int i = 0; i < 40; i++) begin
         saved[i] = 8'($urandom);
         mem[16'h1000 + 16'(i)] = saved[i];
      end
      d0 = done_cnt; q0 = rq_fall;
      push_copy(16'h1000, 16'h2000, 40);
      pulse_start(16'h1000, 16'h2000, 16'd40);
      wait_done("burst_done_seen", d0, 1500);
      repeat (3) @(negedge clk);
      chk("burst_ownerships", 32'(rq_fall - q0), 32'(3));
      for (int i = 0; i < 40; i++) chk("burst_mem", 32'(mem[16'h2000 + 16'(i)]), 32'(saved[i]));

      // Address wrap
      mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
      d0 = done_cnt;
      push_copy(16'hFFFE, 16'h7FFE, 4);
      pulse_start(16'hFFFE, 16'h7FFE, 16'd4);
      wait_done("wrap_done_seen", d0, 400);
      repeat (3) @(negedge clk);
      chk("wrap_mem0", 32'(mem[16'h7FFE]), 32'h11);
      chk("wrap_mem1", 32'(mem[16'h7FFF]), 32'h22);
      chk("wrap_mem2", 32'(mem[16'h8000]), 32'h33);
      chk("wrap_mem3", 32'(mem[16'h8001]), 32'h44);

      // Reset during WR of the second byte
      for (int i = 0; i < 5; i++) mem[16'h3000 + 16'(i)] = 8'(8'hA0 + i);
      push_copy(16'h3000, 16'h4000, 2);
      pulse_start(16'h3000, 16'h4000, 16'd5);
      k = 0; pw = bus.dma_wr_n;
      for (int n = 0; n < 300 && k < 2; n++) begin
         if (bus.dma_wr_n === 1'b0 && pw === 1'b1) k++;
         pw = bus.dma_wr_n;
         if (k < 2) @(negedge clk);
      end
      chk("abort_reached_wr2", 32'(k), 32'(2));
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busrq_n", 32'(bus.busrq_n), 32'(1));
      chk("abort_strobes", 32'({bus.dma_mreq_n, bus.dma_rd_n, bus.dma_wr_n}), 32'(3'b111));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_bus_own", 32'(bus.bus_own), 32'(0));
      reset = 1'b0;
      repeat (6) @(negedge clk);
      d0 = done_cnt;
      push_copy(16'h3002, 16'h4010, 2);
      pulse_start(16'h3002, 16'h4010, 16'd2);
      wait_done("after_abort_done_seen", d0, 400);
      repeat (3) @(negedge clk);
      chk("after_abort_mem0", 32'(mem[16'h4010]), 32'hA2);
      chk("after_abort_mem1", 32'(mem[16'h4011]), 32'hA3);

`ifdef Z80_DMA_SEARCH_EN
      // Search mode: stop at the first F4
      mem[16'h9825] = 8'h50; mem[16'h9826] = 8'hE5; mem[16'h9827] = 8'h41; mem[16'h9828] = 8'hF4;
      for (int i = 0; i < 4; i++) exp_rd.push_back(16'h9825 + 16'(i));
      exp_own.push_back(0);
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
      cmp_mode = 1'b1; match_val = 8'hF4;
      pulse_start(16'h9825, 16'hB000, 16'd8);
      cmp_mode = 1'b0;
      wait_done("search_done_seen", d0, 400);
      repeat (3) @(negedge clk);
      chk("search_match", 32'(match), 32'(1));
      chk("search_match_addr", 32'(match_addr), 32'h9828);
      chk("search_rd_pulses", 32'(rd_cnt - r0), 32'(4));
      chk("search_no_wr", 32'(wr_cnt - w0), 32'(0));
`endif

      chk("sb_wr_empty", 32'(exp_wr.size()), 32'(0));
      chk("sb_rd_empty", 32'(exp_rd.size()), 32'(0));
      chk("sb_own_empty", 32'(exp_own.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
